// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared seven-segment definitions. Holds the digit glyph
//               table (the same patterns the game timer's encoder drives),
//               the non-numeric code points, and the display digit count.
//               Glyph bit order is {g,f,e,d,c,b,a}, active-high.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    typedef logic [6:0] sseg_glyph_t;
    typedef logic [3:0] sseg_code_t;

    localparam int SSEG_NUM_DIGITS = 8;

    localparam sseg_glyph_t SSEG_GLYPH_0    = 7'b0111111;
    localparam sseg_glyph_t SSEG_GLYPH_1    = 7'b0000110;
    localparam sseg_glyph_t SSEG_GLYPH_2    = 7'b1011011;
    localparam sseg_glyph_t SSEG_GLYPH_3    = 7'b1001111;
    localparam sseg_glyph_t SSEG_GLYPH_4    = 7'b1100110;
    localparam sseg_glyph_t SSEG_GLYPH_5    = 7'b1101101;
    localparam sseg_glyph_t SSEG_GLYPH_6    = 7'b1111101;
    localparam sseg_glyph_t SSEG_GLYPH_7    = 7'b0000111;
    localparam sseg_glyph_t SSEG_GLYPH_8    = 7'b1111111;
    localparam sseg_glyph_t SSEG_GLYPH_9    = 7'b1101111;
    localparam sseg_glyph_t SSEG_GLYPH_DASH = 7'b1000000;

    localparam sseg_code_t SSEG_CODE_DASH = 4'hA;
    localparam sseg_code_t SSEG_CODE_BAD  = 4'hF;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pattern_decode
// Description : Combinational inverse of the timer glyph table. Maps a
//               7-segment pattern to its 4-bit digit code.
// Ports       : glyph - segment pattern {g,f,e,d,c,b,a}
//               code  - 0..9, SSEG_CODE_DASH for dash, SSEG_CODE_BAD otherwise
//               bad   - high when the pattern is not in the table
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] code,
    output logic       bad
);

    always_comb begin
        code = SSEG_CODE_BAD;
        bad  = 1'b0;
        case (glyph)
            SSEG_GLYPH_0:    code = 4'h0;
            SSEG_GLYPH_1:    code = 4'h1;
            SSEG_GLYPH_2:    code = 4'h2;
            SSEG_GLYPH_3:    code = 4'h3;
            SSEG_GLYPH_4:    code = 4'h4;
            SSEG_GLYPH_5:    code = 4'h5;
            SSEG_GLYPH_6:    code = 4'h6;
            SSEG_GLYPH_7:    code = 4'h7;
            SSEG_GLYPH_8:    code = 4'h8;
            SSEG_GLYPH_9:    code = 4'h9;
            SSEG_GLYPH_DASH: code = SSEG_CODE_DASH;
            default: begin
                code = SSEG_CODE_BAD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule : sseg_pattern_decode
`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_decoder
// Description : Receiver for the multiplexed 8-digit seven-segment scan.
//               Synchronizes the pins, waits for each selected digit to be
//               stable for SETTLE samples, decodes it into a shadow frame and
//               publishes the frame once all eight digits have been seen.
// Ports       : clock, reset      - clock, async active-high reset
//               seg, dp, an        - display pins (an active-low one-hot)
//               digits             - decoded frame, digit i at [4i+3:4i]
//               dps                - decimal point per digit
//               frame_valid        - one-cycle pulse when digits/dps update
//               err                - sticky: bad glyph or multiple selects
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [7:0]  an,
    output logic [31:0] digits,
    output logic [7:0]  dps,
    output logic        frame_valid,
    output logic        err
);

    // Counter saturation value and the value whose arrival marks a capture.
    localparam logic [2:0] c_settle_max = 3'(SETTLE);
    localparam logic [2:0] c_capture_at = 3'(SETTLE - 2);

    logic [7:0]  r_an_meta, r_an_sync, r_an_prev;
    logic [6:0]  r_seg_meta, r_seg_sync, r_seg_prev;
    logic        r_dp_meta, r_dp_sync, r_dp_prev;
    logic [2:0]  r_count;
    logic [31:0] r_shadow;
    logic [7:0]  r_shadow_dp;
    logic [7:0]  r_mask;

    logic [7:0]  w_sel;
    logic        w_sel_any;
    logic        w_sel_multi;
    logic        w_sel_valid;
    logic        w_same;
    logic        w_step;
    logic        w_capture;
    logic [3:0]  w_code;
    logic        w_bad;

    // ------------------------------------------------------------------
    // Two-stage input synchronizers plus a one-cycle history register
    // used for the stability comparison.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_an_meta  <= 8'hFF;
            r_an_sync  <= 8'hFF;
            r_an_prev  <= 8'hFF;
            r_seg_meta <= '0;
            r_seg_sync <= '0;
            r_seg_prev <= '0;
            r_dp_meta  <= 1'b0;
            r_dp_sync  <= 1'b0;
            r_dp_prev  <= 1'b0;
        end else begin
            r_an_meta  <= an;
            r_an_sync  <= r_an_meta;
            r_an_prev  <= r_an_sync;
            r_seg_meta <= seg;
            r_seg_sync <= r_seg_meta;
            r_seg_prev <= r_seg_sync;
            r_dp_meta  <= dp;
            r_dp_sync  <= r_dp_meta;
            r_dp_prev  <= r_dp_sync;
        end
    end

    // Active-high select. x & (x-1) clears the lowest set bit, so a
    // non-zero result means two or more digits are selected at once.
    assign w_sel       = ~r_an_sync;
    assign w_sel_any   = |w_sel;
    assign w_sel_multi = |(w_sel & (w_sel - 8'd1));
    assign w_sel_valid = w_sel_any & ~w_sel_multi;

    assign w_same    = ({r_an_sync, r_seg_sync, r_dp_sync} ==
                        {r_an_prev, r_seg_prev, r_dp_prev});
    assign w_step    = w_sel_valid & w_same;
    // The counter holds (identical samples - 1); reaching SETTLE-1 means
    // the SETTLE-th identical sample. Saturation above that prevents a
    // second capture within the same dwell.
    assign w_capture = w_step && (r_count == c_capture_at);

    // ------------------------------------------------------------------
    // Stability counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!w_step) begin
            r_count <= '0;
        end else if (r_count != c_settle_max) begin
            r_count <= r_count + 3'd1;
        end
    end

    sseg_pattern_decode u_decode (
        .glyph (r_seg_sync),
        .code  (w_code),
        .bad   (w_bad)
    );

    // ------------------------------------------------------------------
    // Shadow frame: a capture overwrites the selected digit's slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < SSEG_NUM_DIGITS; i++) begin
                if (w_sel[i]) begin
                    r_shadow[4*i +: 4] <= w_code;
                    r_shadow_dp[i]     <= r_dp_sync;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mask tracking and frame commit. A full mask commits on the edge
    // after the last capture; a capture cannot land on that edge because
    // the counter needs at least one more step to revisit the capture
    // point.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask      <= '0;
            digits      <= '0;
            dps         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (r_mask == 8'hFF) begin
                digits      <= r_shadow;
                dps         <= r_shadow_dp;
                frame_valid <= 1'b1;
                r_mask      <= '0;
            end else if (w_capture) begin
                r_mask <= r_mask | w_sel;
            end
        end
    end

    // Sticky error: only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (w_sel_multi || (w_capture && w_bad)) begin
            err <= 1'b1;
        end
    end

endmodule : sseg_scan_decoder
`default_nettype wire
